// File: rtl/key_debounce.sv
// Multi-key debouncer: two-flop synchroniser per active-low key, then an independent
// five-state filter per key that produces a clean level plus registered press,
// release and long-press pulses.
module key_debounce #(
  parameter int unsigned KEY_NUM  = 4,
  parameter int unsigned DB_CNT   = 1_000_000,
  parameter int unsigned LONG_CNT = 50_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_value,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int unsigned CntMax = (DB_CNT > LONG_CNT) ? DB_CNT : LONG_CNT;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] DbLast   = CntW'(DB_CNT - 1);
  localparam logic [CntW-1:0] LongLast = CntW'(LONG_CNT - 1);

  typedef enum logic [2:0] {StIdle, StDbDn, StPressed, StHeld, StDbUp} state_e;

  state_e            state_q [KEY_NUM];
  state_e            state_d [KEY_NUM];
  logic [CntW-1:0]   cnt_q   [KEY_NUM];
  logic [CntW-1:0]   cnt_d   [KEY_NUM];
  logic [KEY_NUM-1:0] long_done_q, long_done_d;
  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [KEY_NUM-1:0] value_q, value_d;
  logic [KEY_NUM-1:0] press_q, press_d;
  logic [KEY_NUM-1:0] release_q, release_d;
  logic [KEY_NUM-1:0] long_q, long_d;

  // Synchroniser: both stages reset to 1 so a held key after reset still needs debouncing.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  // State register: per-key FSM state, counter, long-press latch and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      long_done_q <= '0;
      value_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
    end else begin
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      long_done_q <= long_done_d;
      value_q     <= value_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  // Next-state logic: key_sync low means pressed; counters saturate by leaving the state.
  always_comb begin
    long_done_d = long_done_q;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StIdle: begin
          if (!sync2_q[i]) begin
            state_d[i] = StDbDn;
            cnt_d[i]   = '0;
          end
        end
        StDbDn: begin
          if (sync2_q[i]) begin
            state_d[i] = StIdle;
          end else if (cnt_q[i] == DbLast) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        StPressed: begin
          if (sync2_q[i]) begin
            state_d[i] = StDbUp;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LongLast) begin
            state_d[i]     = StHeld;
            long_done_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        StHeld: begin
          if (sync2_q[i]) begin
            state_d[i] = StDbUp;
            cnt_d[i]   = '0;
          end
        end
        StDbUp: begin
          // A release bounce returns to HELD once long fired, else restarts the long count.
          if (!sync2_q[i]) begin
            if (long_done_q[i]) begin
              state_d[i] = StHeld;
            end else begin
              state_d[i] = StPressed;
              cnt_d[i]   = '0;
            end
          end else if (cnt_q[i] == DbLast) begin
            state_d[i]     = StIdle;
            long_done_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output logic: pulses are decoded from the accepting transitions and registered.
  always_comb begin
    value_d   = value_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      if (state_q[i] == StDbDn && !sync2_q[i] && cnt_q[i] == DbLast) begin
        press_d[i] = 1'b1;
        value_d[i] = 1'b1;
      end
      if (state_q[i] == StPressed && !sync2_q[i] && cnt_q[i] == LongLast) begin
        long_d[i] = 1'b1;
      end
      if (state_q[i] == StDbUp && sync2_q[i] && cnt_q[i] == DbLast) begin
        release_d[i] = 1'b1;
        value_d[i]   = 1'b0;
      end
    end
  end

  assign key_value   = value_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed latency/corner sequences, a vector table, and random
// key activity checked every cycle against a run-length reference model.
module tb_key_debounce;

  localparam int unsigned KeyNum  = 4;
  localparam int unsigned DbCnt   = 4;
  localparam int unsigned LongCnt = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key       = 4'b0000;
  logic [3:0] key_value, key_press, key_release, key_long;

  int n_cmp  = 0;
  int n_fail = 0;

  key_debounce #(
    .KEY_NUM (KeyNum),
    .DB_CNT  (DbCnt),
    .LONG_CNT(LongCnt)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key        (key),
    .key_value  (key_value),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: pipeline delay of two samples, then acceptance by consecutive-sample
  // run lengths (DB_CNT+1 agreeing samples) and a long-press run counted from acceptance.
  logic [3:0] m_s1, m_s2, m_val, m_prs, m_rel, m_lng, m_ldone, m_bnc;
  int         m_zrun [4];
  int         m_orun [4];
  int         m_lrun [4];

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_val = '0; m_prs = '0; m_rel = '0; m_lng = '0; m_ldone = '0; m_bnc = '0;
    for (int k = 0; k < 4; k++) begin
      m_zrun[k] = 0; m_orun[k] = 0; m_lrun[k] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        model_reset();
      end else begin
        m_prs = '0; m_rel = '0; m_lng = '0;
        for (int k = 0; k < 4; k++) begin
          if (!m_val[k]) begin
            m_zrun[k] = m_s2[k] ? 0 : m_zrun[k] + 1;
            if (m_zrun[k] == int'(DbCnt) + 1) begin
              m_val[k] = 1'b1; m_prs[k] = 1'b1;
              m_zrun[k] = 0; m_orun[k] = 0; m_lrun[k] = 0; m_bnc[k] = 1'b0;
            end
          end else if (m_s2[k]) begin
            m_bnc[k]  = 1'b1;
            m_orun[k] = m_orun[k] + 1;
            if (m_orun[k] == int'(DbCnt) + 1) begin
              m_val[k] = 1'b0; m_rel[k] = 1'b1; m_ldone[k] = 1'b0;
              m_orun[k] = 0; m_zrun[k] = 0;
            end
          end else begin
            m_orun[k] = 0;
            if (m_bnc[k]) begin
              m_bnc[k]  = 1'b0;
              m_lrun[k] = 0;
            end else if (!m_ldone[k]) begin
              m_lrun[k] = m_lrun[k] + 1;
              if (m_lrun[k] == int'(LongCnt)) begin
                m_lng[k] = 1'b1; m_ldone[k] = 1'b1;
              end
            end
          end
        end
        m_s2 = m_s1;
        m_s1 = key;
      end
    end
  end

  // Every falling edge: whole output state against the model.
  initial begin
    forever begin
      @(negedge sys_clk);
      n_cmp++;
      if ({key_value, key_press, key_release, key_long} !==
          {m_val, m_prs, m_rel, m_lng}) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t got val=%b prs=%b rel=%b lng=%b exp %b %b %b %b",
                 $time, key_value, key_press, key_release, key_long,
                 m_val, m_prs, m_rel, m_lng);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] key;
    int         cycles;
    logic [3:0] value;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sp, sr, sl, bad;
    int         nl;
    bit         hit;

    vecs[0] = '{4'b1111, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'b1110, 10, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    vecs[2] = '{4'b1111, 10, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vecs[3] = '{4'b0110, 10, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
    vecs[4] = '{4'b1110, 10, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
    vecs[5] = '{4'b1111, 10, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vecs[6] = '{4'b1011, 30, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    vecs[7] = '{4'b1111, 10, 4'b0000, 4'b0000, 4'b0100, 4'b0000};

    // Reset with keys low, then idle with keys high.
    #2;
    chk("rst_outputs", {key_value, key_press, key_release, key_long}, 0);
    @(negedge sys_clk); key = 4'b1111;
    repeat (2) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    bad = '0;
    for (int c = 0; c < 50; c++) begin
      @(posedge sys_clk); #1;
      bad |= key_value | key_press | key_release | key_long;
    end
    chk("rst_idle_50", bad, 0);

    // Vector table.
    for (int v = 0; v < 8; v++) begin
      @(negedge sys_clk); key = vecs[v].key;
      sp = '0; sr = '0; sl = '0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        @(posedge sys_clk); #1;
        sp |= key_press; sr |= key_release; sl |= key_long;
      end
      chk($sformatf("vec%0d_value", v), key_value, vecs[v].value);
      chk($sformatf("vec%0d_press", v), sp, vecs[v].press);
      chk($sformatf("vec%0d_release", v), sr, vecs[v].rel);
      chk($sformatf("vec%0d_long", v), sl, vecs[v].lng);
    end

    // Exact press/release latency on key[0].
    @(negedge sys_clk); key = 4'b1110;
    @(posedge sys_clk);
    repeat (5) @(posedge sys_clk); #1;
    chk("lat_press_e5", key_press, 4'b0000);
    @(posedge sys_clk); #1;
    chk("lat_press_e6", key_press, 4'b0001);
    chk("lat_value_e6", key_value, 4'b0001);
    @(posedge sys_clk); #1;
    chk("lat_press_e7", key_press, 4'b0000);
    @(negedge sys_clk); key = 4'b1111;
    @(posedge sys_clk);
    repeat (5) @(posedge sys_clk); #1;
    chk("lat_rel_r5", key_release, 4'b0000);
    chk("lat_val_r5", key_value, 4'b0001);
    @(posedge sys_clk); #1;
    chk("lat_rel_r6", key_release, 4'b0001);
    chk("lat_val_r6", key_value, 4'b0000);
    repeat (10) @(posedge sys_clk);

    // Long press on key[2]: press at E+6, long at E+22, only once.
    @(negedge sys_clk); key = 4'b1011;
    @(posedge sys_clk);
    repeat (6) @(posedge sys_clk); #1;
    chk("long_press_e6", key_press, 4'b0100);
    repeat (15) @(posedge sys_clk); #1;
    chk("long_e21", key_long, 4'b0000);
    @(posedge sys_clk); #1;
    chk("long_e22", key_long, 4'b0100);
    nl = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge sys_clk); #1;
      if (key_long[2]) nl++;
    end
    chk("long_once", nl, 0);
    @(negedge sys_clk); key = 4'b1111;
    @(posedge sys_clk);
    repeat (6) @(posedge sys_clk); #1;
    chk("long_rel_r6", key_release, 4'b0100);
    repeat (10) @(posedge sys_clk);

    // Bounce on key[1]: 3 low / 1 high for 40 cycles.
    bad = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge sys_clk);
      key[1] = (c >= 40) ? 1'b1 : ((c % 4) == 3);
      @(posedge sys_clk); #1;
      bad |= key_press | key_release | key_long | key_value;
    end
    chk("bounce_quiet", bad, 0);

    // Simultaneous press on keys 3 and 0, then release key 3 only.
    @(negedge sys_clk); key = 4'b0110;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge sys_clk); #1;
      if (key_press != 0) hit = 1'b1;
    end
    chk("simul_press", key_press, 4'b1001);
    @(negedge sys_clk); key = 4'b1110;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge sys_clk); #1;
      if (key_release != 0) hit = 1'b1;
    end
    chk("simul_release", key_release, 4'b1000);
    chk("simul_value", key_value, 4'b0001);
    @(negedge sys_clk); key = 4'b1111;
    repeat (10) @(posedge sys_clk);

    // Reset while key[2] is pressed, then a fresh press after deassertion.
    @(negedge sys_clk); key = 4'b1011;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge sys_clk); #1;
      if (key_value[2]) hit = 1'b1;
    end
    chk("rstmid_value_before", key_value, 4'b0100);
    @(negedge sys_clk); #2 sys_rst_n = 1'b0;
    #1;
    chk("rstmid_async", {key_value, key_press, key_release, key_long}, 0);
    repeat (2) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    sr = '0;
    repeat (6) begin
      @(posedge sys_clk); #1;
      sr |= key_release;
    end
    chk("rstmid_e5", key_press, 4'b0000);
    @(posedge sys_clk); #1;
    chk("rstmid_e6", key_press, 4'b0100);
    chk("rstmid_no_rel", sr, 4'b0000);
    @(negedge sys_clk); key = 4'b1111;
    repeat (10) @(posedge sys_clk);

    // Random activity with varying toggle rates, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      int pct;
      @(negedge sys_clk);
      case ((c / 500) % 4)
        0:       pct = 40;
        1:       pct = 15;
        2:       pct = 5;
        default: pct = 2;
      endcase
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(99) < pct) key[k] = ~key[k];
      end
      if (c == 2222) begin
        #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
      end
    end
    @(negedge sys_clk); key = 4'b1111;
    repeat (20) @(posedge sys_clk);
    @(negedge sys_clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
